// File: rtl/snn_pkg.sv
// Shared constants and arithmetic helpers for the LIF neuron array.
// The helpers work on a fixed 64-bit carrier; callers cast to and from their own widths.
package snn_pkg;
   localparam logic LEAK_SHIFT_MODE = 1'b0;
   localparam logic LEAK_CONST_MODE = 1'b1;
   localparam int unsigned FN_W = 64;

   // a + b, clamped to 2^w - 1 (w <= FN_W)
   function automatic logic [FN_W-1:0] sat_add(input logic [FN_W-1:0] a,
                                                input logic [FN_W-1:0] b,
                                                input int unsigned     w);
      logic [FN_W:0] sum;
      logic [FN_W:0] lim;
      sum = {1'b0, a} + {1'b0, b};
      lim = ((FN_W+1)'(1) << w) - (FN_W+1)'(1);
      return (sum > lim) ? lim[FN_W-1:0] : sum[FN_W-1:0];
   endfunction

   function automatic logic [FN_W-1:0] popcount(input logic [FN_W-1:0] v);
      logic [FN_W-1:0] c;
      c = '0;
      for (int i = 0; i < int'(FN_W); i++) c = c + FN_W'(v[i]);
      return c;
   endfunction
endpackage

// File: rtl/lif_cell.sv
// One leaky integrate-and-fire neuron: membrane potential, refractory counter, spike flop.
// spike_d_o exposes the next-state spike so the top can count spikes in the same cycle.
module lif_cell
   import snn_pkg::*;
#(
   parameter int IN_W       = 8,
   parameter int POT_W      = 12,
   parameter int LEAK_SHIFT = 3,
   parameter int REFRAC     = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             step,
   input  logic [IN_W-1:0]  cur_i,
   input  logic [POT_W-1:0] thr_i,
   input  logic             leak_mode_i,
   input  logic [IN_W-1:0]  leak_val_i,
   output logic             spike_d_o,
   output logic             spike_q_o,
   output logic [POT_W-1:0] pot_o
);
   localparam int RC_W = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

   logic [POT_W-1:0] v_q, v_d;
   logic [RC_W-1:0]  rc_q, rc_d;
   logic             spike_q, spike_d;
   logic [POT_W-1:0] lv_ext, leaked, sum;

   always_comb begin
      lv_ext = POT_W'(leak_val_i);
      if (leak_mode_i == LEAK_CONST_MODE) leaked = (v_q > lv_ext) ? v_q - lv_ext : '0;
      else                                leaked = v_q - (v_q >> LEAK_SHIFT);
      sum     = POT_W'(sat_add(FN_W'(leaked), FN_W'(cur_i), POT_W));
      v_d     = v_q;
      rc_d    = rc_q;
      spike_d = 1'b0;
      if (step) begin
         if (rc_q != '0) begin
            rc_d = rc_q - RC_W'(1);
            v_d  = '0;
         end else if (sum >= thr_i) begin
            spike_d = 1'b1;
            v_d     = '0;
            rc_d    = RC_W'(REFRAC);
         end else begin
            v_d = sum;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         v_q     <= '0;
         rc_q    <= '0;
         spike_q <= 1'b0;
      end else begin
         v_q     <= v_d;
         rc_q    <= rc_d;
         spike_q <= spike_d;
      end
   end

   assign spike_d_o = spike_d;
   assign spike_q_o = spike_q;
   assign pot_o     = v_q;
endmodule

// File: rtl/lif_neuron_array.sv
// Array of LIF neurons with a shared saturating spike counter and a potential observation mux.
module lif_neuron_array
   import snn_pkg::*;
#(
   parameter int N_NEURONS  = 4,
   parameter int IN_W       = 8,
   parameter int POT_W      = 12,
   parameter int LEAK_SHIFT = 3,
   parameter int REFRAC     = 3,
   parameter int CNT_W      = 16,
   localparam int SEL_W     = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      step,
   input  logic [N_NEURONS*IN_W-1:0] in_cur,
   input  logic [POT_W-1:0]          threshold,
   input  logic                      leak_mode,
   input  logic [IN_W-1:0]           leak_val,
   output logic [N_NEURONS-1:0]      spike,
   output logic                      spike_any,
   input  logic [SEL_W-1:0]          pot_sel,
   output logic [POT_W-1:0]          pot_out,
   output logic [CNT_W-1:0]          spike_count
);
   logic [N_NEURONS-1:0]            spike_next;
   logic [N_NEURONS-1:0][POT_W-1:0] pot;
   logic [POT_W-1:0]                pot_tbl [2**SEL_W];
   logic [CNT_W-1:0]                cnt_q, cnt_d;

   generate
      for (genvar g = 0; g < N_NEURONS; g++) begin : g_cell
         lif_cell #(
            .IN_W(IN_W), .POT_W(POT_W), .LEAK_SHIFT(LEAK_SHIFT), .REFRAC(REFRAC)
         ) u_cell (
            .clk        (clk),
            .reset      (reset),
            .step       (step),
            .cur_i      (in_cur[g*IN_W +: IN_W]),
            .thr_i      (threshold),
            .leak_mode_i(leak_mode),
            .leak_val_i (leak_val),
            .spike_d_o  (spike_next[g]),
            .spike_q_o  (spike[g]),
            .pot_o      (pot[g])
         );
      end
      // Pad the mux table so unused select codes read as zero.
      for (genvar g = 0; g < 2**SEL_W; g++) begin : g_tbl
         if (g < N_NEURONS) begin : g_real
            assign pot_tbl[g] = pot[g];
         end else begin : g_pad
            assign pot_tbl[g] = '0;
         end
      end
   endgenerate

   always_comb begin
      cnt_d = CNT_W'(sat_add(FN_W'(cnt_q), popcount(FN_W'(spike_next)), CNT_W));
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign spike_any   = |spike;
   assign pot_out     = pot_tbl[pot_sel];
   assign spike_count = cnt_q;
endmodule

// File: tb/tb_lif_neuron_array.sv
// Table-driven bench for lif_neuron_array with a scoreboard queue of expected outputs.
module tb_lif_neuron_array;
   logic        clk = 1'b0;
   logic        reset, step, leak_mode;
   logic [31:0] in_cur;
   logic [11:0] threshold;
   logic [7:0]  leak_val;
   logic [3:0]  spike;
   logic        spike_any;
   logic [1:0]  pot_sel;
   logic [11:0] pot_out;
   logic [15:0] spike_count;

   lif_neuron_array dut (
      .clk(clk), .reset(reset), .step(step), .in_cur(in_cur), .threshold(threshold),
      .leak_mode(leak_mode), .leak_val(leak_val), .spike(spike), .spike_any(spike_any),
      .pot_sel(pot_sel), .pot_out(pot_out), .spike_count(spike_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          rst, stp;
      logic [31:0] cur;
      logic [11:0] thr;
      bit          mode;
      logic [7:0]  lv;
      logic [1:0]  sel;
      logic [3:0]  esp;
      logic [11:0] epot;
   } vec_t;

   typedef struct {
      bit          chk;
      logic [3:0]  esp;
      logic [11:0] epot;
      logic [15:0] ecnt;
   } exp_t;

   vec_t        tbl[$];
   exp_t        sb[$];
   int          n_pass = 0, n_total = 0;
   int unsigned cnt_model = 0;

   function automatic vec_t mk(bit r, bit s, logic [31:0] c, logic [11:0] t, bit m,
                               logic [7:0] l, logic [1:0] sl, logic [3:0] es, logic [11:0] ep);
      vec_t v;
      v.rst = r; v.stp = s; v.cur = c; v.thr = t; v.mode = m;
      v.lv = l; v.sel = sl; v.esp = es; v.epot = ep;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic apply(input vec_t v, input bit chk);
      exp_t e;
      @(negedge clk);
      reset = v.rst; step = v.stp; in_cur = v.cur; threshold = v.thr;
      leak_mode = v.mode; leak_val = v.lv; pot_sel = v.sel;
      if (v.rst) cnt_model = 0;
      else begin
         cnt_model = cnt_model + $countones(v.esp);
         if (cnt_model > 65535) cnt_model = 65535;
      end
      e.chk = chk; e.esp = v.esp; e.epot = v.epot; e.ecnt = 16'(cnt_model);
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      if (e.chk) begin
         check("spike", 32'(spike), 32'(e.esp));
         check("spike_any", 32'(spike_any), 32'(|e.esp));
         check("pot_out", 32'(pot_out), 32'(e.epot));
         check("spike_count", 32'(spike_count), 32'(e.ecnt));
      end
   endtask

   initial begin
      reset = 1'b1; step = 1'b0; in_cur = '0; threshold = '0;
      leak_mode = 1'b1; leak_val = '0; pot_sel = '0;

      // reset state, every pot_sel reads zero
      tbl.push_back(mk(1, 0, 0, 100, 1, 0, 0, 4'h0, 0));
      tbl.push_back(mk(1, 0, 0, 100, 1, 0, 0, 4'h0, 0));
      tbl.push_back(mk(0, 1, 0, 100, 1, 0, 0, 4'h0, 0));
      for (int s = 1; s < 4; s++) tbl.push_back(mk(0, 0, 0, 100, 1, 0, 2'(s), 4'h0, 0));
      // integration, idle hold, fire, refractory
      tbl.push_back(mk(0, 1, 30, 100, 1, 0, 0, 4'h0, 30));
      tbl.push_back(mk(0, 1, 30, 100, 1, 0, 0, 4'h0, 60));
      tbl.push_back(mk(0, 1, 30, 100, 1, 0, 0, 4'h0, 90));
      tbl.push_back(mk(0, 0, 30, 100, 1, 0, 0, 4'h0, 90));
      tbl.push_back(mk(0, 1, 30, 100, 1, 0, 0, 4'h1, 0));
      for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 1, 30, 100, 1, 0, 0, 4'h0, 0));
      tbl.push_back(mk(0, 1, 30, 100, 1, 0, 0, 4'h0, 30));
      // shift leak on neuron 1
      tbl.push_back(mk(1, 0, 0, 4095, 0, 0, 1, 4'h0, 0));
      tbl.push_back(mk(0, 1, 32'h4000, 4095, 0, 0, 1, 4'h0, 64));
      tbl.push_back(mk(0, 1, 0, 4095, 0, 0, 1, 4'h0, 56));
      tbl.push_back(mk(0, 1, 0, 4095, 0, 0, 1, 4'h0, 49));
      tbl.push_back(mk(0, 1, 0, 4095, 0, 0, 1, 4'h0, 43));
      // constant leak, clamped at zero
      tbl.push_back(mk(1, 0, 0, 4095, 1, 10, 0, 4'h0, 0));
      tbl.push_back(mk(0, 1, 5, 4095, 1, 10, 0, 4'h0, 5));
      tbl.push_back(mk(0, 1, 0, 4095, 1, 10, 0, 4'h0, 0));
      tbl.push_back(mk(0, 1, 50, 4095, 1, 10, 0, 4'h0, 50));
      tbl.push_back(mk(0, 1, 0, 4095, 1, 10, 0, 4'h0, 40));
      // saturation at 4095 fires all four
      tbl.push_back(mk(1, 0, 0, 4095, 1, 0, 3, 4'h0, 0));
      for (int k = 1; k <= 16; k++)
         tbl.push_back(mk(0, 1, 32'hFFFF_FFFF, 4095, 1, 0, 3, 4'h0, 12'(255 * k)));
      tbl.push_back(mk(0, 1, 32'hFFFF_FFFF, 4095, 1, 0, 3, 4'hF, 0));
      // simultaneous firing with refractory gap
      tbl.push_back(mk(1, 0, 0, 10, 1, 0, 2, 4'h0, 0));
      tbl.push_back(mk(0, 1, 32'h1414_1414, 10, 1, 0, 2, 4'hF, 0));
      for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 1, 32'h1414_1414, 10, 1, 0, 2, 4'h0, 0));
      tbl.push_back(mk(0, 1, 32'h1414_1414, 10, 1, 0, 2, 4'hF, 0));
      // reset during refractory, then normal integration
      tbl.push_back(mk(1, 0, 0, 100, 1, 0, 0, 4'h0, 0));
      tbl.push_back(mk(0, 1, 30, 100, 1, 0, 0, 4'h0, 30));
      tbl.push_back(mk(0, 1, 30, 100, 1, 0, 0, 4'h0, 60));
      tbl.push_back(mk(0, 1, 30, 100, 1, 0, 0, 4'h0, 90));
      tbl.push_back(mk(0, 1, 30, 100, 1, 0, 0, 4'h1, 0));
      tbl.push_back(mk(0, 1, 30, 100, 1, 0, 0, 4'h0, 0));
      tbl.push_back(mk(1, 1, 30, 100, 1, 0, 0, 4'h0, 0));
      tbl.push_back(mk(0, 1, 30, 100, 1, 0, 0, 4'h0, 30));

      foreach (tbl[i]) apply(tbl[i], 1'b1);

      // long run: counter climbs to 65532, saturates at 65535 and holds
      apply(mk(1, 0, 0, 10, 1, 0, 0, 4'h0, 0), 1'b1);
      for (int k = 0; k <= 65536; k++)
         apply(mk(0, 1, 32'h1414_1414, 10, 1, 0, 0, (k % 4 == 0) ? 4'hF : 4'h0, 0),
               (k >= 65528) && (k % 4 == 0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/lif_neuron_array.md
# lif_neuron_array

Parametrised array of N leaky integrate-and-fire neurons with runtime threshold, selectable leak mode, refractory period and a saturating aggregate spike counter. It generalises the single-neuron block behind the TinySNN top level to a multi-channel, configurable core. It sits between the ui_in/uio input mapping and the output pin mapping.

## Interface
Parameters:
- N_NEURONS, 4, number of neurons (≥1)
- IN_W, 8, width of each input current
- POT_W, 12, membrane potential width (POT_W > IN_W)
- LEAK_SHIFT, 3, shift amount for shift-leak mode
- REFRAC, 3, refractory length in steps (0 = none)
- CNT_W, 16, spike counter width

Ports:
- clk  in  1  clock; single clock domain
- reset  in  1  synchronous, active-high reset
- step  in  1  advance all neurons one timestep this cycle
- in_cur  in  N_NEURONS*IN_W  packed input currents, neuron i at [i*IN_W +: IN_W]
- threshold  in  POT_W  firing threshold, sampled on step
- leak_mode  in  1  0 = shift leak, 1 = constant-subtract leak
- leak_val  in  IN_W  constant leak amount (leak_mode=1)
- spike  out  N_NEURONS  per-neuron spike pulses
- spike_any  out  1  OR of spike
- pot_sel  in  max(1,$clog2(N_NEURONS))  neuron whose potential is observed
- pot_out  out  POT_W  potential of neuron pot_sel (combinational mux of registers)
- spike_count  out  CNT_W  total spikes since reset, saturating

## Operation
- Per neuron state: V (POT_W), refractory counter rc (fits REFRAC), spike flop.
- On cycle with step=1, for each neuron i:
  - rc>0: rc←rc−1, V held at 0, spike←0, input ignored.
  - rc==0: leaked = V−(V>>LEAK_SHIFT) (mode 0) or max(V−leak_val,0) (mode 1); sum = leaked + in_cur[i] computed in POT_W+1 bits, saturated to 2^POT_W−1.
  - sum ≥ threshold: spike←1, V←0, rc←REFRAC. Else spike←0, V←sum.
- threshold=0: every non-refractory step fires.
- Cycle with step=0: V and rc hold; spike←0 (spikes are single-cycle pulses).
- spike_count ← min(spike_count + popcount(next spike), 2^CNT_W−1), updated in the same cycle as spike.
- Out-of-range pot_sel (N_NEURONS not a power of 2): pot_out=0.

## Timing
- Reset value of all outputs: spike=0, spike_any=0, spike_count=0, pot_out=0 (all V=0, all rc=0).
- Latency: step sampled at edge t → spike/V/spike_count visible after edge t, valid for one cycle.
- Back-to-back step every cycle supported; no stall, no handshake.
- spike_any combinational from spike register.
- reset has priority over step in the same cycle; reset mid-refractory clears rc, so the next step integrates normally.
- Saturated V at 2^POT_W−1 never wraps.

## Structure
- Package snn_pkg: leak mode constants (LEAK_SHIFT_MODE=0, LEAK_CONST_MODE=1), saturating-add function, popcount function.
- Sub-module lif_cell: one neuron (V, rc, spike), instantiated N_NEURONS times via generate; top holds the counter, pot_out mux and spike_any.

## Test plan
- Reset: assert reset 2 cycles, then step with in_cur=0 → spike=0, spike_count=0, pot_out=0 for every pot_sel.
- Integration/refractory: threshold=100, leak_mode=1, leak_val=0, neuron0 in=30 each step → V 30,60,90, spike on 4th step, V=0; steps 5–7 ignored (V=0); step 8 → V=30.
- Shift leak: leak_mode=0, neuron1 in=64 once then 0 → V 64, 56, 49, 43; no spike with threshold=4095.
- Saturation: threshold=4095, leak_mode=1, leak_val=0, in=255 each step → V=4080 after 16 steps, step 17 saturates to 4095 and fires, V=0.
- Simultaneous: threshold=10, all in=20 → spike=4'hF, spike_any=1, spike_count +4 per firing step; preload counter near 2^CNT_W−1 (run long) → holds 65535.
- Reset mid-operation: assert reset during neuron0 refractory (rc=2) with step=1 → V=0, rc=0, spike=0; next step with in=30 gives V=30.
